// File: rtl/mux_stream_pkg.sv
// Shared types and helpers for the streaming channel mux.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package mux_stream_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    localparam int DEF_N_CH = 4;
    localparam int DEF_W    = 8;

    // Modulo-n increment used to advance the round-robin start point.
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant search with packet lock: picks the first requester at or after rr_ptr.
// Latency: purely combinational, zero cycles.
// Backpressure: none here; the caller qualifies the grant with its own load enable.
module rr_arbiter #(
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req_i,
    input  logic [SEL_W-1:0] rr_ptr_i,
    input  logic             lock_i,
    input  logic [SEL_W-1:0] locked_ch_i,
    output logic [SEL_W-1:0] grant_o,
    output logic             grant_vld_o
);

    // Locked: only the owning channel may be granted. Unlocked: scan from the
    // farthest offset down to offset 0 so the nearest requester wins last.
    always_comb begin
        grant_o     = '0;
        grant_vld_o = 1'b0;
        if (lock_i) begin
            grant_o = locked_ch_i;
            for (int i = 0; i < N_CH; i++) begin
                if (SEL_W'(i) == locked_ch_i) begin
                    grant_vld_o = req_i[i];
                end
            end
        end else begin
            for (int k = N_CH - 1; k >= 0; k--) begin
                for (int i = 0; i < N_CH; i++) begin
                    if ((int'(rr_ptr_i) + k == i || int'(rr_ptr_i) + k == i + N_CH) && req_i[i]) begin
                        grant_o     = SEL_W'(i);
                        grant_vld_o = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mux_stream_rr.sv
// N_CH-to-1 stream mux, fixed select or round-robin with packet lock, registered output.
// Latency: 1 cycle from input transfer to out_valid; 1 beat/cycle when out_ready stays high.
// Backpressure: in_ready goes low for all channels while the output register is full and stalled.
module mux_stream_rr
    import mux_stream_pkg::*;
#(
    parameter  int N_CH  = DEF_N_CH,
    parameter  int W     = DEF_W,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_last,
    output logic [N_CH-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic              out_last,
    output logic [SEL_W-1:0]  out_ch,
    input  logic              out_ready
);

    mode_e            mode_s;
    logic             load_en;
    logic             fix_vld;
    logic [SEL_W-1:0] arb_g;
    logic             arb_vld;
    logic [SEL_W-1:0] g;
    logic             grant_vld;
    logic             xfer;
    logic [W-1:0]     sel_dat;
    logic             sel_last;

    logic             out_valid_q;
    logic [W-1:0]     out_data_q;
    logic             out_last_q;
    logic [SEL_W-1:0] out_ch_q;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [SEL_W-1:0] locked_ch_q, locked_ch_d;

    assign mode_s = mode_e'(mode);

    // The output register can take a beat when empty or being drained this cycle.
    assign load_en = !out_valid_q || out_ready;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req_i       (in_valid),
        .rr_ptr_i    (rr_ptr_q),
        .lock_i      (lock_q),
        .locked_ch_i (locked_ch_q),
        .grant_o     (arb_g),
        .grant_vld_o (arb_vld)
    );

    // Fixed-mode request check; an out-of-range sel matches no channel and never grants.
    always_comb begin
        fix_vld = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (SEL_W'(i) == sel) begin
                fix_vld = in_valid[i];
            end
        end
    end

    assign g         = (mode_s == MODE_RR) ? arb_g   : sel;
    assign grant_vld = (mode_s == MODE_RR) ? arb_vld : fix_vld;
    assign xfer      = rst_n && load_en && grant_vld;

    // Steer the granted channel's data/last and raise its single ready bit.
    always_comb begin
        sel_dat  = '0;
        sel_last = 1'b0;
        in_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (SEL_W'(i) == g) begin
                sel_dat     = in_data[i*W +: W];
                sel_last    = in_last[i];
                in_ready[i] = xfer;
            end
        end
    end

    // Lock follows packet boundaries in round-robin; fixed mode drops any lock and freezes the pointer.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        locked_ch_d = locked_ch_q;
        if (mode_s == MODE_FIXED) begin
            lock_d = 1'b0;
        end else if (xfer) begin
            if (sel_last) begin
                lock_d   = 1'b0;
                rr_ptr_d = SEL_W'(next_idx(int'(g), N_CH));
            end else begin
                lock_d      = 1'b1;
                locked_ch_d = g;
            end
        end
    end

    // Arbitration state and the single output register; reset discards any in-flight packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            locked_ch_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            locked_ch_q <= locked_ch_d;
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sel_dat;
                out_last_q  <= sel_last;
                out_ch_q    <= g;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_stream_rr.sv
// Randomised bench for mux_stream_rr with a queue-based reference model and scoreboard.
// Stimulus is applied on the falling edge; the monitor samples shortly after it.
// Output stalls are exercised through random and directed out_ready patterns.
module tb_mux_stream_rr;

    typedef struct packed {
        logic [7:0] dat;
        logic       last;
        logic [1:0] ch;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic [1:0]  out_ch;
    logic        out_ready;

    int checks;
    int fails;

    beat_t q[$];
    int    pushed_now;

    // Reference state, in terms of packets: who owns the output, where the next search starts.
    int m_owner;
    int m_next_start;
    bit m_out_full;

    mux_stream_rr #(.N_CH(4), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One cycle of stimulus: drive, check in_ready against the model, record any accepted beat.
    task automatic step(input logic m, input logic [1:0] s, input logic [3:0] v,
                        input logic [31:0] d, input logic [3:0] l, input logic r);
        int    gi;
        bit    take;
        logic [3:0] exp_rdy;
        beat_t b;
        @(negedge clk);
        mode = m; sel = s; in_valid = v; in_data = d; in_last = l; out_ready = r;
        #1;
        gi = -1;
        if (m == 1'b0) begin
            if (v[s]) gi = int'(s);
        end else if (m_owner >= 0) begin
            if (v[m_owner]) gi = m_owner;
        end else begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_next_start + k) % 4;
                if (gi < 0 && v[c]) gi = c;
            end
        end
        take    = (!m_out_full || r) && (gi >= 0);
        exp_rdy = take ? (4'b0001 << gi) : 4'b0000;
        chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
        pushed_now = 0;
        if (take) begin
            b.dat  = d[gi*8 +: 8];
            b.last = l[gi];
            b.ch   = 2'(gi);
            q.push_back(b);
            pushed_now = 1;
            m_out_full = 1'b1;
            if (m == 1'b1) begin
                if (l[gi]) begin
                    m_owner      = -1;
                    m_next_start = (gi + 1) % 4;
                end else begin
                    m_owner = gi;
                end
            end
        end else if (r) begin
            m_out_full = 1'b0;
        end
        if (m == 1'b0) m_owner = -1;
    endtask

    // Assert reset between clock edges with every channel requesting; outputs must clear at once.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        in_valid = 4'hF;
        in_last = 4'h0;
        mode = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {24'd0, out_data},  32'd0);
        chk("rst_out_last",  {31'd0, out_last},  32'd0);
        chk("rst_out_ch",    {30'd0, out_ch},    32'd0);
        chk("rst_in_ready",  {28'd0, in_ready},  32'd0);
        q.delete();
        pushed_now   = 0;
        m_owner      = -1;
        m_next_start = 0;
        m_out_full   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hold_in_ready", {28'd0, in_ready}, 32'd0);
        in_valid = 4'h0;
        rst_n = 1'b1;
    endtask

    // Monitor: the head of the queue must sit in the output register whenever it is valid.
    initial begin
        beat_t h;
        forever begin
            @(negedge clk);
            #2;
            chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() > pushed_now)});
            if (out_valid && q.size() > 0) begin
                h = q[0];
                chk("out_data", {24'd0, out_data}, {24'd0, h.dat});
                chk("out_last", {31'd0, out_last}, {31'd0, h.last});
                chk("out_ch",   {30'd0, out_ch},   {30'd0, h.ch});
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        logic        rm;
        logic [3:0]  rv, rl;
        logic [31:0] rd;
        checks = 0; fails = 0; pushed_now = 0;
        m_owner = -1; m_next_start = 0; m_out_full = 1'b0;
        rst_n = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'h0;
        in_data = 32'h0; in_last = 4'h0; out_ready = 1'b1;

        do_reset();

        // Fixed select of channel 2 with every channel valid.
        repeat (4) step(1'b0, 2'd2, 4'hF, 32'h44A5_2211, 4'h0, 1'b1);

        // Round-robin fairness with single-beat packets: 0,1,2,3,0.
        for (int i = 0; i < 5; i++) step(1'b1, 2'd0, 4'hF, 32'h3322_1100 + 32'h0101_0101 * i, 4'hF, 1'b1);

        // Channel 1 holds a 3-beat packet while 0 and 2 also request, then 2 follows.
        step(1'b1, 2'd0, 4'b0111, 32'h0022_1100, 4'b0000, 1'b1);
        step(1'b1, 2'd0, 4'b0111, 32'h0023_1201, 4'b0000, 1'b1);
        step(1'b1, 2'd0, 4'b0111, 32'h0024_1302, 4'b0010, 1'b1);
        step(1'b1, 2'd0, 4'b0101, 32'h0025_1403, 4'b0101, 1'b1);

        // Three stall cycles, then drain and load together.
        step(1'b1, 2'd0, 4'hF, 32'hD4C3_B2A1, 4'hF, 1'b0);
        step(1'b1, 2'd0, 4'hF, 32'hD5C4_B3A2, 4'hF, 1'b0);
        step(1'b1, 2'd0, 4'hF, 32'hD6C5_B4A3, 4'hF, 1'b0);
        step(1'b1, 2'd0, 4'hF, 32'hD7C6_B5A4, 4'hF, 1'b1);
        step(1'b1, 2'd0, 4'hF, 32'hD8C7_B6A5, 4'hF, 1'b1);

        // Channel 3 locks a packet, reset lands mid-packet, channel 0 wins afterwards.
        step(1'b1, 2'd0, 4'b1000, 32'h7700_0000, 4'b0000, 1'b1);
        step(1'b1, 2'd0, 4'b1001, 32'h7800_0001, 4'b0000, 1'b1);
        do_reset();
        step(1'b1, 2'd0, 4'hF, 32'h9382_7160, 4'hF, 1'b1);
        step(1'b1, 2'd0, 4'hF, 32'h9483_7261, 4'hF, 1'b1);

        // Random traffic, mostly round-robin, with occasional mode flips and stalls.
        rm = 1'b1;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 24) == 0) rm = ~rm;
            rv = 4'($urandom);
            rd = $urandom;
            for (int c = 0; c < 4; c++) rl[c] = ($urandom_range(0, 2) == 0);
            step(rm, 2'($urandom_range(0, 3)), rv, rd, rl, ($urandom_range(0, 3) != 0));
        end

        // Drain and confirm nothing is left outstanding.
        repeat (3) step(1'b1, 2'd0, 4'h0, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        #3;
        chk("drain_empty", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
